// File: rtl/dft_pkg.sv
// Shared types and defaults for the DFT sample feeder.
// Optional zero-fill on underrun is enabled by defining FEEDER_ZERO_FILL_EN.
package dft_pkg;

    localparam int DFT_WIDTH = 12;
    localparam int DFT_N_MAX = 32;

    typedef struct packed {
        logic signed [DFT_WIDTH-1:0] re;
        logic signed [DFT_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/dft_sample_fifo.sv
// Synchronous show-ahead FIFO of complex samples.
// The head entry is always visible on dout while the FIFO is not empty.
module dft_sample_fifo
    import dft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  cplx_t         din,
    input  logic          pop,
    output cplx_t         dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    cplx_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (cnt_q == (AW+1)'(DEPTH));
        empty    = (cnt_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // Power-of-two depth lets the pointers wrap naturally.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        level    = cnt_q;
        dout     = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/dft_sample_feeder.sv
// Feeds buffered complex samples to the DFT core as sample + write strobe.
// Define FEEDER_ZERO_FILL_EN to strobe zero samples on underrun.
module dft_sample_feeder
    import dft_pkg::*;
#(
    parameter int WIDTH      = DFT_WIDTH,
    parameter int N_MAX      = DFT_N_MAX,
    parameter int LOG_N_MAX  = $clog2(N_MAX),
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_W      = 8
) (
    input  logic                          i_sys_clk,
    input  logic                          i_sys_rst,
    input  logic                          i_en,
    input  logic                          i_clr,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic signed [WIDTH-1:0]       i_re,
    input  logic signed [WIDTH-1:0]       i_im,
    input  logic [GAP_W-1:0]              i_gap,
    input  logic                          i_dft_done,
    output logic signed [WIDTH-1:0]       o_x [0:1],
    output logic                          o_wr,
    output logic [LOG_N_MAX-1:0]          o_sample_idx,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_underrun
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    feeder_state_t          state_q, state_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [LOG_N_MAX-1:0]   idx_q, idx_d;
    logic                   started_q, started_d;
    logic                   underrun_q, underrun_d;
    cplx_t                  x_q, x_d;

    cplx_t                  push_data;
    cplx_t                  head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LW-1:0]          fifo_level;
    logic                   pop;
    logic                   fire;

    always_comb begin
        push_data.re = i_re;
        push_data.im = i_im;
    end

    dft_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_sys_clk),
        .rst_n (i_sys_rst),
        .push  (i_valid),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        started_d  = started_q;
        underrun_d = underrun_q;
        x_d        = x_q;
        pop        = 1'b0;
        fire       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_en) state_d = ARM;
            end
            ARM: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else if (i_dft_done) begin
                    if (!fifo_empty) begin
                        state_d = STROBE;
                        pop     = 1'b1;
                        x_d     = head;
                        fire    = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
`ifdef FEEDER_ZERO_FILL_EN
                        state_d = STROBE;
                        x_d     = '0;
                        fire    = 1'b1;
`endif
                    end
                end
            end
            STROBE: begin
                if (i_gap != '0) begin
                    state_d = GAP;
                    gap_d   = i_gap;
                end else begin
                    state_d = ARM;
                end
            end
            GAP: begin
                gap_d = gap_q - GAP_W'(1);
                // The ARM cycle is part of the gap, so leave one count early.
                if (gap_q <= GAP_W'(2)) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase

        if (fire) begin
            if (started_q) begin
                idx_d = (idx_q == LOG_N_MAX'(N_MAX - 1)) ? '0
                                                         : idx_q + LOG_N_MAX'(1);
            end
            started_d = 1'b1;
        end

        if (i_clr) begin
            idx_d      = '0;
            underrun_d = 1'b0;
            started_d  = fire;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            idx_q      <= '0;
            started_q  <= 1'b0;
            underrun_q <= 1'b0;
            x_q        <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            started_q  <= started_d;
            underrun_q <= underrun_d;
            x_q        <= x_d;
        end
    end

    always_comb begin
        o_ready      = !fifo_full;
        o_level      = fifo_level;
        o_wr         = (state_q == STROBE);
        o_x[0]       = x_q.re;
        o_x[1]       = x_q.im;
        o_sample_idx = idx_q;
        o_underrun   = underrun_q;
    end

endmodule

// File: tb/tb_dft_sample_feeder.sv
// Directed + randomized bench for dft_sample_feeder against a queue model.
module tb_dft_sample_feeder;

    localparam int W  = 12;
    localparam int NM = 32;
    localparam int FD = 16;
    localparam int GW = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic                clr = 1'b0;
    logic                valid = 1'b0;
    logic                ready;
    logic                done = 1'b0;
    logic                wr;
    logic                underrun;
    logic signed [W-1:0] re = '0;
    logic signed [W-1:0] im = '0;
    logic [GW-1:0]       gap = '0;
    logic signed [W-1:0] x [0:1];
    logic [4:0]          idx;
    logic [4:0]          level;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_since = 0;
    int s0;
    int acc_cnt;
    logic [23:0] q[$];
    int strobe_cyc[$];
    int strobe_idx[$];

    always #5 clk = ~clk;

    dft_sample_feeder dut (
        .i_sys_clk    (clk),
        .i_sys_rst    (rst_n),
        .i_en         (en),
        .i_clr        (clr),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_re         (re),
        .i_im         (im),
        .i_gap        (gap),
        .i_dft_done   (done),
        .o_x          (x),
        .o_wr         (wr),
        .o_sample_idx (idx),
        .o_level      (level),
        .o_underrun   (underrun)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rand();
        re = 12'($urandom_range(0, 4095));
        im = 12'($urandom_range(0, 4095));
    endtask

    // One clock: model decides acceptance/pop from pre-edge state, then checks.
    task automatic tick();
        bit          acc;
        bit          clr_now;
        int          pre;
        int          e_idx;
        logic [23:0] d;
        logic [23:0] e;
        acc     = valid && (q.size() < FD);
        clr_now = clr;
        pre     = q.size();
        d       = {re, im};
        @(posedge clk);
        #1;
        cyc++;
        if (wr) begin
            e = (pre == 0) ? 24'd0 : q.pop_front();
            if (clr_now) begin
                e_idx   = 0;
                n_since = 1;
            end else begin
                e_idx   = n_since % NM;
                n_since++;
            end
            check("x_re", {20'd0, x[0]}, {20'd0, e[23:12]});
            check("x_im", {20'd0, x[1]}, {20'd0, e[11:0]});
            check("idx", {27'd0, idx}, e_idx);
            strobe_cyc.push_back(cyc);
            strobe_idx.push_back(int'(idx));
        end else if (clr_now) begin
            n_since = 0;
        end
        if (acc) q.push_back(d);
        check("level", {27'd0, level}, q.size());
        check("ready", {31'd0, ready}, {31'd0, q.size() < FD});
    endtask

    task automatic wait_strobe(input int max, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!wr && n < max);
        check(tag, {31'd0, wr}, 1);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_wr", {31'd0, wr}, 0);
        check("rst_x", {8'd0, x[0], x[1]}, 0);
        check("rst_level", {27'd0, level}, 0);
        check("rst_ready", {31'd0, ready}, 1);
        check("rst_idx", {27'd0, idx}, 0);
        check("rst_underrun", {31'd0, underrun}, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Basic single sample, one-edge latency
        en = 1'b1;
        gap = '0;
        done = 1'b0;
        tick();
        tick();
        re = 12'sd100;
        im = -12'sd100;
        valid = 1'b1;
        tick();
        check("basic_no_wr_yet", {31'd0, wr}, 0);
        valid = 1'b0;
        done = 1'b1;
        tick();
        check("basic_wr", {31'd0, wr}, 1);
        check("basic_re", {20'd0, x[0]}, 32'h064);
        check("basic_im", {20'd0, x[1]}, 32'hf9c);
        check("basic_idx", {27'd0, idx}, 0);
        tick();
        check("basic_wr_one_cycle", {31'd0, wr}, 0);

        // Pacing with gap=3
        done = 1'b0;
        gap = 8'd3;
        repeat (6) tick();
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            tick();
        end
        valid = 1'b0;
        done = 1'b1;
        s0 = strobe_cyc.size();
        repeat (20) tick();
        check("pace_count_ge4", {31'd0, strobe_cyc.size() >= s0 + 4}, 1);
        if (strobe_cyc.size() >= s0 + 4) begin
            for (int i = 0; i < 3; i++) begin
                check("pace_spacing",
                      strobe_cyc[s0+i+1] - strobe_cyc[s0+i], 4);
            end
        end

        // Core busy holds off strobes
        done = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_rand();
            tick();
        end
        valid = 1'b0;
        s0 = strobe_cyc.size();
        repeat (10) tick();
        check("busy_no_strobe", strobe_cyc.size(), s0);
        done = 1'b1;
        wait_strobe(10, "busy_resume_strobe");
        repeat (10) tick();

        // Fill to full with strobing off, then stream 40 samples
        en = 1'b0;
        gap = '0;
        repeat (10) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        valid = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            if (q.size() < FD) acc_cnt++;
            tick();
        end
        check("full_ready", {31'd0, ready}, 0);
        check("full_level", {27'd0, level}, 16);
        s0 = strobe_idx.size();
        en = 1'b1;
        for (int i = 0; i < 400 && (strobe_idx.size() - s0) < 40; i++) begin
            valid = (acc_cnt < 40);
            drive_rand();
            if (valid && q.size() < FD) acc_cnt++;
            tick();
        end
        valid = 1'b0;
        check("stream_count", strobe_idx.size() - s0, 40);
        if (strobe_idx.size() >= s0 + 40) begin
            check("wrap_first", strobe_idx[s0], 0);
            check("wrap_31", strobe_idx[s0+31], 31);
            check("wrap_0", strobe_idx[s0+32], 0);
            check("wrap_7", strobe_idx[s0+39], 7);
        end

        // Underrun on empty FIFO
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_underrun", {31'd0, underrun}, 0);
        check("clr_idx", {27'd0, idx}, 0);
        s0 = strobe_cyc.size();
        repeat (6) tick();
        check("underrun_set", {31'd0, underrun}, 1);
`ifdef FEEDER_ZERO_FILL_EN
        check("zf_strobes", {31'd0, strobe_cyc.size() > s0}, 1);
        check("zf_idx_adv", {31'd0, idx != 5'd0}, 1);
`else
        check("underrun_no_wr", strobe_cyc.size(), s0);
        check("underrun_idx", {27'd0, idx}, 0);
`endif
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr2_underrun", {31'd0, underrun}, 0);
        check("clr2_idx", {27'd0, idx}, 0);

        // Enable drops during gap
        done = 1'b0;
        gap = 8'd5;
        repeat (8) tick();
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            tick();
        end
        valid = 1'b0;
        done = 1'b1;
        wait_strobe(20, "en_drop_strobe");
        en = 1'b0;
        s0 = strobe_cyc.size();
        repeat (15) tick();
        check("en_drop_no_wr", strobe_cyc.size(), s0);
        check("en_drop_level", {27'd0, level}, 2);

        // Asynchronous reset mid-stream with level 5
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            tick();
        end
        valid = 1'b0;
        check("pre_rst_level", {27'd0, level}, 5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr", {31'd0, wr}, 0);
        check("arst_x", {8'd0, x[0], x[1]}, 0);
        check("arst_level", {27'd0, level}, 0);
        check("arst_ready", {31'd0, ready}, 1);
        check("arst_idx", {27'd0, idx}, 0);
        q.delete();
        n_since = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
